// File: rtl/gray_conv_arbiter_if.sv
// Request/response bus for gray_conv_arbiter.
// Optional port req_inv exists only when GRAY_CONV_INV_EN is defined.
interface gray_conv_arbiter_if #(
  parameter int WIDTH = 4
);
  logic [1:0]       req_valid;
  logic [WIDTH-1:0] req_b0;
  logic [WIDTH-1:0] req_b1;
  logic [1:0]       req_ready;
`ifdef GRAY_CONV_INV_EN
  logic [1:0]       req_inv;
`endif
  logic             resp_valid;
  logic [WIDTH-1:0] resp_g;
  logic             resp_id;
  logic             resp_ready;
  logic [7:0]       conv_cnt;

  // Requester/consumer side.
  modport master (
`ifdef GRAY_CONV_INV_EN
    output req_inv,
`endif
    output req_valid, req_b0, req_b1, resp_ready,
    input  req_ready, resp_valid, resp_g, resp_id, conv_cnt
  );

  // Converter side.
  modport slave (
`ifdef GRAY_CONV_INV_EN
    input  req_inv,
`endif
    input  req_valid, req_b0, req_b1, resp_ready,
    output req_ready, resp_valid, resp_g, resp_id, conv_cnt
  );
endinterface

// File: rtl/gray_conv_arbiter.sv
// Two-requester round-robin arbiter feeding a one-entry binary-to-Gray
// conversion register. Macro GRAY_CONV_INV_EN adds per-requester req_inv,
// selecting Gray-to-binary decoding for that requester's requests.
//
// state | meaning
// IDLE  | output register empty
// BUSY  | output register holds a response awaiting retire
module gray_conv_arbiter #(
  parameter int WIDTH = 4
) (
  input logic           clk,
  input logic           rst_n,
  gray_conv_arbiter_if.slave bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, state_nxt;
  logic             prio;
  logic             winner;
  logic             any_valid;
  logic             accept;
  logic [1:0]       ready;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] conv;
  logic [WIDTH-1:0] resp_g_q;
  logic             resp_id_q;
  logic [7:0]       cnt_q;

  // Pick the winner: sole requester, or the priority holder under contention.
  always_comb begin
    any_valid = |bus.req_valid;
    winner    = (&bus.req_valid) ? prio : bus.req_valid[1];
    operand   = winner ? bus.req_b1 : bus.req_b0;
  end

  // Convert the granted operand (encode by default, optional decode).
  always_comb begin
    conv = operand ^ (operand >> 1);
`ifdef GRAY_CONV_INV_EN
    if (bus.req_inv[winner]) begin
      conv[WIDTH-1] = operand[WIDTH-1];
      for (int i = WIDTH - 2; i >= 0; i--) begin
        conv[i] = conv[i+1] ^ operand[i];
      end
    end
`endif
  end

  // Next state and handshake; a full register can reload only while retiring.
  always_comb begin
    state_nxt = state;
    ready     = 2'b00;
    accept    = 1'b0;
    if (rst_n && any_valid && (state == IDLE || bus.resp_ready)) begin
      ready[winner] = 1'b1;
      accept        = 1'b1;
    end
    case (state)
      IDLE: if (accept) state_nxt = BUSY;
      BUSY: if (bus.resp_ready && !accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, output register, priority and accept counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      resp_g_q  <= '0;
      resp_id_q <= 1'b0;
      cnt_q     <= 8'd0;
      prio      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        resp_g_q  <= conv;
        resp_id_q <= winner;
        cnt_q     <= cnt_q + 8'd1;
        prio      <= ~winner;
      end
    end
  end

  assign bus.req_ready  = ready;
  assign bus.resp_valid = (state == BUSY);
  assign bus.resp_g     = resp_g_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.conv_cnt   = cnt_q;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Scoreboard bench for gray_conv_arbiter: directed scenarios plus random
// traffic checked against a behavioural model of the arbiter and converter.
module tb_gray_conv_arbiter;
  localparam int W = 4;

  logic clk;
  logic rst_n;

  gray_conv_arbiter_if #(.WIDTH(W)) bus ();

  gray_conv_arbiter #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  logic [W:0] exp_q[$];      // {id, code}

  // Model state
  bit       m_full = 0;
  bit       m_prio = 0;
  int       m_cnt  = 0;
  bit       m_after_reset = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_encode(input logic [W-1:0] b);
    logic [W-1:0] g;
    g[W-1] = b[W-1];
    for (int i = 0; i < W - 1; i++) g[i] = b[i+1] ^ b[i];
    return g;
  endfunction

  function automatic logic [W-1:0] ref_decode(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // One cycle: drive inputs after the edge, check pre-edge outputs, advance model.
  task automatic cycle(input logic [1:0] v, input logic [W-1:0] b0, input logic [W-1:0] b1,
                       input logic rdy, input logic rst, input logic [1:0] inv);
    int       win;
    bit       acc;
    logic [1:0] exp_rdy;
    logic [W-1:0] opnd;
    logic [W-1:0] code;
    @(posedge clk);
    #1;
    bus.req_valid  = v;
    bus.req_b0     = b0;
    bus.req_b1     = b1;
    bus.resp_ready = rdy;
    rst_n          = rst;
`ifdef GRAY_CONV_INV_EN
    bus.req_inv    = inv;
`endif
    #1;
    check("resp_valid", bus.resp_valid, m_full);
    check("conv_cnt", bus.conv_cnt, m_cnt);
    if (m_after_reset) begin
      check("reset_resp_g", bus.resp_g, 0);
      check("reset_resp_id", bus.resp_id, 0);
    end
    if (v == 2'b11) win = m_prio;
    else            win = v[1] ? 1 : 0;
    acc = rst && (v != 2'b00) && (!m_full || rdy);
    exp_rdy = 2'b00;
    if (acc) exp_rdy[win] = 1'b1;
    check("req_ready", bus.req_ready, exp_rdy);
    if (!rst) begin
      m_full = 0; m_cnt = 0; m_prio = 0; m_after_reset = 1;
      exp_q.delete();
    end else begin
      m_after_reset = 0;
      if (acc) begin
        opnd = (win == 1) ? b1 : b0;
        code = ref_encode(opnd);
`ifdef GRAY_CONV_INV_EN
        if (inv[win]) code = ref_decode(opnd);
`endif
        exp_q.push_back({win[0], code});
        m_full = 1;
        m_prio = (win == 0);
        m_cnt  = (m_cnt + 1) % 256;
      end else if (m_full && rdy) begin
        m_full = 0;
      end
    end
  endtask

  // Monitor: compare every retiring response and hold-stability under backpressure.
  logic [W-1:0] held_g;
  logic         held_id;
  bit           hold_pend = 0;
  logic [W:0]   exp_item;
  always @(negedge clk) begin
    if (hold_pend) begin
      check("hold_valid", bus.resp_valid, 1);
      check("hold_g", bus.resp_g, held_g);
      check("hold_id", bus.resp_id, held_id);
    end
    if (bus.resp_valid && bus.resp_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", 1, 0);
      end else begin
        exp_item = exp_q.pop_front();
        check("resp_id", bus.resp_id, exp_item[W]);
        check("resp_g", bus.resp_g, exp_item[W-1:0]);
      end
    end
    hold_pend = bus.resp_valid && !bus.resp_ready && rst_n;
    held_g    = bus.resp_g;
    held_id   = bus.resp_id;
  end

  initial begin
    rst_n          = 1'b0;
    bus.req_valid  = 2'b00;
    bus.req_b0     = '0;
    bus.req_b1     = '0;
    bus.resp_ready = 1'b0;
`ifdef GRAY_CONV_INV_EN
    bus.req_inv    = 2'b00;
`endif
    // Reset, then single request
    cycle(2'b00, 4'h0, 4'h0, 1'b0, 1'b0, 2'b00);
    cycle(2'b00, 4'h0, 4'h0, 1'b0, 1'b0, 2'b00);
    cycle(2'b01, 4'b1011, 4'h0, 1'b1, 1'b1, 2'b00);
    cycle(2'b00, 4'h0, 4'h0, 1'b1, 1'b1, 2'b00);
    // Contention round-robin from fresh priority
    cycle(2'b00, 4'h0, 4'h0, 1'b0, 1'b0, 2'b00);
    for (int i = 0; i < 4; i++) cycle(2'b11, 4'b0110, 4'b1111, 1'b1, 1'b1, 2'b00);
    cycle(2'b00, 4'h0, 4'h0, 1'b1, 1'b1, 2'b00);
    // Backpressure
    cycle(2'b01, 4'b1001, 4'h0, 1'b1, 1'b1, 2'b00);
    for (int i = 0; i < 3; i++) cycle(2'b01, 4'b0011, 4'h0, 1'b0, 1'b1, 2'b00);
    cycle(2'b00, 4'h0, 4'h0, 1'b1, 1'b1, 2'b00);
    // Reset mid-operation, then contention must go to requester 0
    cycle(2'b10, 4'h0, 4'b0101, 1'b1, 1'b1, 2'b00);
    cycle(2'b11, 4'h3, 4'h5, 1'b0, 1'b0, 2'b00);
    cycle(2'b11, 4'b1100, 4'b0101, 1'b1, 1'b1, 2'b00);
    cycle(2'b00, 4'h0, 4'h0, 1'b1, 1'b1, 2'b00);
    // Counter wrap: 256 accepts after reset
    cycle(2'b00, 4'h0, 4'h0, 1'b0, 1'b0, 2'b00);
    for (int i = 0; i < 256; i++) cycle(2'b01, 4'(i), 4'h0, 1'b1, 1'b1, 2'b00);
    cycle(2'b00, 4'h0, 4'h0, 1'b1, 1'b1, 2'b00);
`ifdef GRAY_CONV_INV_EN
    // Inverse mode on requester 1
    cycle(2'b10, 4'h0, 4'b1110, 1'b1, 1'b1, 2'b10);
    cycle(2'b00, 4'h0, 4'h0, 1'b1, 1'b1, 2'b00);
`endif
    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      logic rst_r;
      rst_r = ($urandom_range(0, 99) != 0);
      cycle(2'($urandom), 4'($urandom), 4'($urandom),
            rst_r ? ($urandom_range(0, 3) != 0) : 1'b0, rst_r, 2'($urandom));
    end
    // Drain
    for (int i = 0; i < 4; i++) cycle(2'b00, 4'h0, 4'h0, 1'b1, 1'b1, 2'b00);
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
